// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes and anode polarity helper for the seven-segment scanner
//
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low (0 = segment lit).
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b0111111;

    // Glyphs for nibble values 0..F; the decimal decoder substitutes SEG_DASH above 9.
    localparam seg_t SEG_DIGIT [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Pin level for one anode: enable selects the digit, active_high picks the board polarity.
    function automatic logic anode_level(input logic enable, input bit active_high);
        return active_high ? enable : ~enable;
    endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// rtl/seven_segment_decode.sv - combinational nibble to active-low segment decoder
//
// Ports:
//   nibble   - digit value 0..15
//   hex_mode - 1: show A..F glyphs; 0: values above 9 show a dash
//   blank    - force all segments dark
//   seg      - {g,f,e,d,c,b,a}, active-low
module seven_segment_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DIGIT[nibble];
        if (!hex_mode && (nibble > 4'd9)) begin
            seg = SEG_DASH;
        end
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - time-multiplexed N-digit common-anode seven-segment driver
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   en           - scan enable; when low the scan freezes and the display goes dark
//   value        - packed nibbles, digit i = value[4i+3:4i], digit 0 on a[0]
//   dp           - per-digit decimal point request (1 = lit)
//   digit_blank  - per-digit forced blank (1 = dark)
//   hex_mode     - 1 = hex glyphs, 0 = decimal with dash for 10..15
//   lz_blank     - leading-zero blanking enable
//   out, out_dp  - registered active-low segments and decimal point
//   a            - registered anode enables, polarity set by ANODE_ACTIVE_HIGH
//   frame_start  - one-cycle pulse in the cycle after the snapshot reloads
module seven_segment_scan
    import seg7_pkg::*;
#(
    parameter int N_DIGITS          = 4,
    parameter int REFRESH_DIV       = 100000,
    parameter int DEAD_CYCLES       = 16,
    parameter bit ANODE_ACTIVE_HIGH = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     digit_blank,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    output logic [6:0]              out,
    output logic                    out_dp,
    output logic [N_DIGITS-1:0]     a,
    output logic                    frame_start
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic             A_OFF    = ANODE_ACTIVE_HIGH ? 1'b0 : 1'b1;

    if ((N_DIGITS < 1) || (N_DIGITS > 8) || (REFRESH_DIV < 2) ||
        (DEAD_CYCLES < 0) || (DEAD_CYCLES > REFRESH_DIV - 1)) begin : g_param_check
        $error("seven_segment_scan: parameter out of range");
    end

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [4*N_DIGITS-1:0]  snap_value_q, snap_value_d;
    logic [N_DIGITS-1:0]    snap_dp_q, snap_dp_d;
    logic [N_DIGITS-1:0]    snap_blank_q, snap_blank_d;
    logic                   snap_hex_q, snap_hex_d;
    logic                   snap_lz_q, snap_lz_d;
    logic [6:0]             out_q, out_d;
    logic                   out_dp_q, out_dp_d;
    logic [N_DIGITS-1:0]    a_q, a_d;
    logic                   frame_start_q, frame_start_d;

    logic                   tick;
    logic                   frame_wrap;
    logic                   active;
    logic [N_DIGITS-1:0]    lz_mask;
    logic [3:0]             cur_nibble;
    logic                   cur_dp;
    logic                   cur_blank;

    // Prescaler, digit index and frame snapshot.
    always_comb begin
        tick       = (cnt_q == CNT_LAST) && en;
        frame_wrap = tick && (idx_q == IDX_LAST);

        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Inputs are only sampled as the scan returns to digit 0 so a frame never mixes values.
        snap_value_d = snap_value_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;
        snap_hex_d   = snap_hex_q;
        snap_lz_d    = snap_lz_q;
        if (frame_wrap) begin
            snap_value_d = value;
            snap_dp_d    = dp;
            snap_blank_d = digit_blank;
            snap_hex_d   = hex_mode;
            snap_lz_d    = lz_blank;
        end

        frame_start_d = frame_wrap;
    end

    // Per-slot digit selection, dead time and anode drive.
    always_comb begin
        int  cnt_int;
        logic lead_zero;

        cnt_int = int'(cnt_q);
        // The first DEAD_CYCLES of every slot keep all anodes off so the previous digit cannot ghost.
        active  = en && (cnt_int >= DEAD_CYCLES);

        // Walk from the most significant digit down; a digit stays blank while everything above it is zero.
        lead_zero = snap_lz_q;
        lz_mask   = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (snap_value_q[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lz_mask[i] = lead_zero;
            end
        end

        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b1;
        a_d        = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = snap_value_q[4*i +: 4];
                cur_dp     = snap_dp_q[i];
                cur_blank  = snap_blank_q[i] | lz_mask[i];
            end
            a_d[i] = anode_level(active && (idx_q == IDX_W'(i)), ANODE_ACTIVE_HIGH);
        end

        // Decimal point ignores blanking but still goes dark with the anodes.
        out_dp_d = active ? ~cur_dp : 1'b1;
    end

    seven_segment_decode u_decode (
        .nibble   (cur_nibble),
        .hex_mode (snap_hex_q),
        .blank    (cur_blank || !active),
        .seg      (out_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_value_q  <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '1;
            snap_hex_q    <= 1'b0;
            snap_lz_q     <= 1'b0;
            out_q         <= SEG_BLANK;
            out_dp_q      <= 1'b1;
            a_q           <= {N_DIGITS{A_OFF}};
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_value_q  <= snap_value_d;
            snap_dp_q     <= snap_dp_d;
            snap_blank_q  <= snap_blank_d;
            snap_hex_q    <= snap_hex_d;
            snap_lz_q     <= snap_lz_d;
            out_q         <= out_d;
            out_dp_q      <= out_dp_d;
            a_q           <= a_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign out         = out_q;
    assign out_dp      = out_dp_q;
    assign a           = a_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// tb/tb_seven_segment_scan.sv - directed self-checking bench for seven_segment_scan
module tb_seven_segment_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SX = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_blank;
    logic        hex_mode;
    logic        lz_blank;
    logic [6:0]  out;
    logic        out_dp;
    logic [3:0]  a;
    logic        frame_start;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    seven_segment_scan #(
        .N_DIGITS          (4),
        .REFRESH_DIV       (8),
        .DEAD_CYCLES       (2),
        .ANODE_ACTIVE_HIGH (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .value       (value),
        .dp          (dp),
        .digit_blank (digit_blank),
        .hex_mode    (hex_mode),
        .lz_blank    (lz_blank),
        .out         (out),
        .out_dp      (out_dp),
        .a           (a),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge at which frame_start is high.
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((frame_start !== 1'b1) && (n < 80));
        chk({tag, " frame_start seen"}, frame_start, 1);
    endtask

    // After reset release the snapshot is blank, so segments stay dark until the first reload.
    task automatic dark_until_frame(input string tag);
        int n;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n = k;
            if (frame_start === 1'b1) break;
            chk({tag, " dark out"}, out, SX);
        end
        chk({tag, " cycles to first frame"}, n, 32);
    endtask

    // Called at the negedge on which frame_start is high; checks the 32 cycles of that frame.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpv);
        logic [6:0] segs [4];
        logic [3:0] exp_a;
        logic [6:0] exp_out;
        logic       exp_dp;
        int         slot;
        bit         act;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        segs[3] = s3;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            slot    = (j - 1) / 8;
            act     = ((j - 1) % 8) >= 2;
            exp_a   = act ? (4'b0001 << slot) : 4'b0000;
            exp_out = act ? segs[slot] : SX;
            exp_dp  = act ? ~dpv[slot] : 1'b1;
            chk({tag, " a"}, a, exp_a);
            chk({tag, " out"}, out, exp_out);
            chk({tag, " out_dp"}, out_dp, exp_dp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b1;
        value       = 16'h1234;
        dp          = 4'b0000;
        digit_blank = 4'b0000;
        hex_mode    = 1'b0;
        lz_blank    = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset out", out, SX);
        chk("reset out_dp", out_dp, 1);
        chk("reset a", a, 4'b0000);
        chk("reset frame_start", frame_start, 0);

        rst_n = 1'b1;
        dark_until_frame("post-reset");
        check_frame("1234", S4, S3, S2, S1, 4'b0000);

        value = 16'h0070; lz_blank = 1'b1; dp = 4'b1000;
        wait_frame("lz 0070");
        check_frame("lz 0070", S0, S7, SX, SX, 4'b1000);

        value = 16'h0000; dp = 4'b0000;
        wait_frame("lz 0000");
        check_frame("lz 0000", S0, SX, SX, SX, 4'b0000);

        value = 16'hAB9F; lz_blank = 1'b0; hex_mode = 1'b1;
        wait_frame("hex AB9F");
        check_frame("hex AB9F", SF, S9, SB, SA, 4'b0000);

        hex_mode = 1'b0;
        wait_frame("dec AB9F");
        check_frame("dec AB9F", SD, S9, SD, SD, 4'b0000);

        value = 16'h1234; digit_blank = 4'b0010; dp = 4'b0101;
        wait_frame("blank+dp");
        check_frame("blank+dp", S4, SX, S2, S1, 4'b0101);

        digit_blank = 4'b0000; dp = 4'b0000; value = 16'h1111;
        wait_frame("snap 1111");
        value = 16'h2222;
        check_frame("snap hold 1111", S1, S1, S1, S1, 4'b0000);
        chk("snap reload pulse", frame_start, 1);
        check_frame("snap new 2222", S2, S2, S2, S2, 4'b0000);

        value = 16'h1234;
        wait_frame("en pause");
        repeat (19) @(negedge clk);
        chk("pre-pause a", a, 4'b0100);
        chk("pre-pause out", out, S2);
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("paused a", a, 4'b0000);
            chk("paused out", out, SX);
            chk("paused out_dp", out_dp, 1);
        end
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("resumed a", a, 4'b0100);
            chk("resumed out", out, S2);
        end
        @(negedge clk);
        chk("slot3 dead0 a", a, 4'b0000);
        @(negedge clk);
        chk("slot3 dead1 a", a, 4'b0000);
        @(negedge clk);
        chk("slot3 active a", a, 4'b1000);
        chk("slot3 active out", out, S1);

        rst_n = 1'b0;
        #1;
        chk("async reset out", out, SX);
        chk("async reset a", a, 4'b0000);
        chk("async reset out_dp", out_dp, 1);
        chk("async reset frame_start", frame_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dark_until_frame("re-reset");
        check_frame("after re-reset", S4, S3, S2, S1, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
